// File: rtl/mmio_pkg.sv
// Shared memory-map constants for the switch peripheral and its address decoder.
package mmio_pkg;

  // Word offsets inside the switch register block (address[3:2]).
  localparam logic [1:0] SW_STATE_OFF   = 2'd0;
  localparam logic [1:0] SW_CHANGED_OFF = 2'd1;
  localparam logic [1:0] SW_IRQ_EN_OFF  = 2'd2;

  // Base-region selectors, kept in step with addressDecoder.
  localparam logic [1:0] SWITCH_BASE = 2'b10;
  localparam logic [1:0] LED_BASE    = 2'b01;

endpackage

// File: rtl/switch_debouncer.sv
// One switch input: 2-FF synchroniser followed by a mismatch-count debouncer.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic changed_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          mismatch;
  logic          accept;

  // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  always_comb begin
    count_d  = count_q;
    level_d  = level_q;
    mismatch = (sync_q != level_q);
    accept   = mismatch && (count_q == CW'(DEBOUNCE_CYCLES - 1));
    if (!mismatch) begin
      count_d = '0;
    end else if (accept) begin
      count_d = '0;
      level_d = sync_q;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= raw;
      sync_q  <= sync1_q;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  assign level         = level_q;
  // Combinational so the top can set its sticky flag on the same edge as the level update.
  assign changed_pulse = accept;

endmodule

// File: rtl/switch_peripheral.sv
// Memory-mapped switch block: debounced state, sticky W1C change flags,
// per-switch interrupt enables and a registered level interrupt.
module switch_peripheral
  import mmio_pkg::*;
#(
  parameter int unsigned OPERAND_LENGTH  = 31,
  parameter int unsigned NUM_SWITCHES    = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      selSwitch,
  input  logic                      readEnable,
  input  logic                      writeEnable,
  input  logic [OPERAND_LENGTH:0]   address,
  input  logic [OPERAND_LENGTH:0]   writeData,
  input  logic [NUM_SWITCHES-1:0]   switches,
  output logic [OPERAND_LENGTH:0]   readData,
  output logic                      irq
);

  localparam int unsigned DW = OPERAND_LENGTH + 1;

  logic [NUM_SWITCHES-1:0] levels;
  logic [NUM_SWITCHES-1:0] pulses;
  logic [NUM_SWITCHES-1:0] changed_q;
  logic [NUM_SWITCHES-1:0] changed_d;
  logic [NUM_SWITCHES-1:0] irq_en_q;
  logic [NUM_SWITCHES-1:0] irq_en_d;
  logic [NUM_SWITCHES-1:0] wr_bits;
  logic                    irq_q;
  logic                    wr_en;
  logic                    rd_en;
  logic [1:0]              offset;
  logic                    unused_bus_bits;

  for (genvar g = 0; g < int'(NUM_SWITCHES); g++) begin : g_sw
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk           (clk),
      .rst_n         (rst_n),
      .raw           (switches[g]),
      .level         (levels[g]),
      .changed_pulse (pulses[g])
    );
  end

  assign wr_en   = selSwitch && writeEnable;
  assign rd_en   = selSwitch && readEnable;
  assign offset  = address[3:2];
  assign wr_bits = writeData[NUM_SWITCHES-1:0];
  assign unused_bus_bits = ^{address, writeData};

  // Register next-state; a debounced transition wins over a same-cycle W1C.
  always_comb begin
    changed_d = changed_q;
    irq_en_d  = irq_en_q;
    if (wr_en && (offset == SW_CHANGED_OFF)) begin
      changed_d = changed_q & ~wr_bits;
    end
    if (wr_en && (offset == SW_IRQ_EN_OFF)) begin
      irq_en_d = wr_bits;
    end
    changed_d = changed_d | pulses;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed_q <= '0;
      irq_en_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      changed_q <= changed_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= |(changed_d & irq_en_d);
    end
  end

  // Zero-wait read mux reflecting state before the current edge.
  always_comb begin
    readData = '0;
    if (rd_en) begin
      case (offset)
        SW_STATE_OFF:   readData = DW'(levels);
        SW_CHANGED_OFF: readData = DW'(changed_q);
        SW_IRQ_EN_OFF:  readData = DW'(irq_en_q);
        default:        readData = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_switch_peripheral.sv
// Scoreboard bench for switch_peripheral: stimulus queues expected values, a negedge monitor checks them.
module tb_switch_peripheral;

  logic        clk;
  logic        rst_n;
  logic        selSwitch;
  logic        readEnable;
  logic        writeEnable;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [15:0] switches;
  logic [31:0] readData;
  logic        irq;
  logic        probe;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  switch_peripheral #(
    .OPERAND_LENGTH (31),
    .NUM_SWITCHES   (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .selSwitch  (selSwitch),
    .readEnable (readEnable),
    .writeEnable(writeEnable),
    .address    (address),
    .writeData  (writeData),
    .switches   (switches),
    .readData   (readData),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation for every presented read or probe.
  always @(negedge clk) begin
    if (probe || (selSwitch && readEnable)) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_output: scoreboard empty, readData=%h irq=%0b", readData, irq);
      end else begin
        exp_t e;
        logic [31:0] act;
        e = exp_q.pop_front();
        act = e.is_irq ? {31'b0, irq} : readData;
        if (act !== e.value) begin
          errors = errors + 1;
          $display("FAIL %s: got %h expected %h", e.name, act, e.value);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_read(input logic [1:0] off, input logic sel,
                          input logic [31:0] exp, input string nm);
    exp_t e;
    e.name = nm; e.is_irq = 1'b0; e.value = exp;
    exp_q.push_back(e);
    selSwitch  = sel;
    readEnable = 1'b1;
    address    = {28'h0, off, 2'b00};
    probe      = !sel;
    tick();
    selSwitch  = 1'b0;
    readEnable = 1'b0;
    probe      = 1'b0;
    address    = '0;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic sel, input logic [31:0] data);
    selSwitch   = sel;
    writeEnable = 1'b1;
    address     = {28'h0, off, 2'b00};
    writeData   = data;
    tick();
    selSwitch   = 1'b0;
    writeEnable = 1'b0;
    address     = '0;
    writeData   = '0;
  endtask

  task automatic check_irq(input logic exp, input string nm);
    exp_t e;
    e.name = nm; e.is_irq = 1'b1; e.value = {31'b0, exp};
    exp_q.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; selSwitch = 1'b0; readEnable = 1'b0; writeEnable = 1'b0;
    address = '0; writeData = '0; switches = 16'hFFFF; probe = 1'b0;

    // Reset with all switches high: three reset edges.
    tick();
    bus_read(2'd0, 1'b1, 32'h0, "rst_state");
    check_irq(1'b0, "rst_irq");
    rst_n = 1'b1;
    ticks(5);
    bus_read(2'd0, 1'b1, 32'h0,        "state_before_edge6");
    bus_read(2'd0, 1'b1, 32'h0000FFFF, "state_after_edge6");
    bus_read(2'd1, 1'b1, 32'h0000FFFF, "changed_after_release");
    check_irq(1'b0, "irq_disabled");

    // Return switches low, then clear all flags.
    switches = 16'h0000;
    ticks(8);
    bus_write(2'd1, 1'b1, 32'hFFFF_FFFF);
    bus_read(2'd1, 1'b1, 32'h0, "changed_cleared");
    bus_read(2'd0, 1'b1, 32'h0, "state_low");

    // Three-cycle glitch must be rejected.
    switches = 16'h0008;
    ticks(3);
    switches = 16'h0000;
    ticks(6);
    bus_read(2'd0, 1'b1, 32'h0, "glitch3_state");
    bus_read(2'd1, 1'b1, 32'h0, "glitch3_changed");
    check_irq(1'b0, "glitch3_irq");

    // Four-cycle pulse is accepted on edge 6.
    switches = 16'h0008;
    ticks(4);
    switches = 16'h0000;
    tick();
    bus_read(2'd0, 1'b1, 32'h0,        "pulse4_before_edge6");
    bus_read(2'd0, 1'b1, 32'h00000008, "pulse4_state");
    check_irq(1'b0, "pulse4_irq_disabled");
    ticks(6);
    bus_read(2'd0, 1'b1, 32'h0,        "pulse4_fell");
    bus_write(2'd1, 1'b1, 32'h0000_0008);
    bus_read(2'd1, 1'b1, 32'h0,        "pulse4_changed_cleared");

    // Interrupt asserts on the accepting edge, W1C drops it.
    bus_write(2'd2, 1'b1, 32'h0000_0008);
    bus_read(2'd2, 1'b1, 32'h00000008, "irq_en_rw");
    switches = 16'h0008;
    ticks(5);
    check_irq(1'b0, "irq_before_accept");
    check_irq(1'b1, "irq_on_accept");
    bus_read(2'd0, 1'b1, 32'h00000008, "irq_state");
    bus_write(2'd1, 1'b1, 32'h0000_0008);
    check_irq(1'b0, "irq_after_w1c");
    bus_read(2'd1, 1'b1, 32'h0, "changed_after_w1c");

    // W1C on the same edge as the falling acceptance: set wins.
    switches = 16'h0000;
    ticks(5);
    bus_write(2'd1, 1'b1, 32'h0000_0008);
    bus_read(2'd1, 1'b1, 32'h00000008, "collision_changed");
    check_irq(1'b1, "collision_irq");
    bus_read(2'd0, 1'b1, 32'h0, "collision_state");
    bus_write(2'd1, 1'b1, 32'h0000_0008);
    check_irq(1'b0, "collision_irq_cleared");

    // Decode gating and ignored writes.
    bus_write(2'd2, 1'b0, 32'h0000_00F0);
    bus_read(2'd2, 1'b0, 32'h0,        "unselected_read");
    bus_read(2'd2, 1'b1, 32'h00000008, "unselected_write_ignored");
    bus_write(2'd3, 1'b1, 32'hFFFF_FFFF);
    bus_read(2'd3, 1'b1, 32'h0,        "offset3_read");
    bus_read(2'd1, 1'b1, 32'h0,        "offset3_write_ignored");
    bus_write(2'd0, 1'b1, 32'hFFFF_FFFF);
    bus_read(2'd0, 1'b1, 32'h0,        "state_write_ignored");
    bus_write(2'd2, 1'b1, 32'hFFFF_FFFF);
    bus_read(2'd2, 1'b1, 32'h0000FFFF, "irq_en_upper_bits_dropped");
    check_irq(1'b0, "irq_no_changes");

    ticks(2);
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_peripheral.md
# switch_peripheral

Memory-mapped switch input peripheral that sits directly downstream of `addressDecoder` and consumes its `selSwitch` output. It synchronises and debounces the board switches, tracks which switches changed, and raises an interrupt request when enabled changes occur. It presents three word registers to the processor load/store path with combinational read data, so it drops into the single-cycle datapath next to data memory and the LED block.

## Interface
- `OPERAND_LENGTH`, 31: MSB index of address/data buses, matching `addressDecoder`.
- `NUM_SWITCHES`, 16: number of switch inputs, 1..32.
- `DEBOUNCE_CYCLES`, 4: consecutive mismatching cycles required to accept a new level, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- `selSwitch`  in  1  from `addressDecoder`; access targets this block.
- `readEnable`  in  1  load in progress.
- `writeEnable`  in  1  store in progress.
- `address`  in  OPERAND_LENGTH+1  full byte address; only `address[3:2]` is decoded here.
- `writeData`  in  OPERAND_LENGTH+1  store data.
- `switches`  in  NUM_SWITCHES  raw asynchronous switch levels.
- `readData`  out  OPERAND_LENGTH+1  load data, combinational.
- `irq`  out  1  level interrupt request, registered.

## Operation
- Register map, word offset `address[3:2]`:
  - 0 SW_STATE (RO): debounced levels.
  - 1 SW_CHANGED (W1C): sticky per-switch change flags.
  - 2 SW_IRQ_EN (RW): per-switch interrupt enable.
  - 3: reads 0, writes ignored.
- Read data:
  - `readData` = selected register, zero-extended to OPERAND_LENGTH+1 bits, when `selSwitch && readEnable`.
  - Otherwise `readData` = 0.
- Writes:
  - Occur only when `selSwitch && writeEnable`.
  - Writes to SW_STATE are ignored.
  - Bits of `writeData` at or above NUM_SWITCHES are ignored.
- Per-switch path:
  - 2-FF synchroniser yields `sync`.
  - Debouncer compares `sync` with `debounced`. On mismatch, `count` increments. When a mismatch coincides with `count == DEBOUNCE_CYCLES-1`: `debounced <= sync`, `count <= 0`, and the change flag is set. On match, `count <= 0`.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches `debounced`.
- SW_CHANGED bit updates:
  - Set by any `debounced` transition, rising or falling.
  - Cleared by writing 1 to that bit.
  - Set and clear in the same cycle: set wins.
- `irq` is registered: `irq <= |(SW_CHANGED_next & SW_IRQ_EN_next)`.
- Reset (`rst_n` low at an edge) clears synchronisers, counters, `debounced`, SW_CHANGED, SW_IRQ_EN and `irq`. Reset mid-debounce discards the partial count. A switch held high through reset therefore produces a 0→1 transition (and change flag) DEBOUNCE_CYCLES+2 edges after release.

## Timing
- Reset values: `readData` 0, `irq` 0, all registers 0.
- Input latency: a `switches` change before edge 1 is seen at `sync` after edge 2 and appears in SW_STATE after edge 2+DEBOUNCE_CYCLES, if stable throughout.
- Change flag and `debounced` update on the same edge; `irq` asserts on that same edge.
- Reads are zero-wait; the value reflects register state before the current edge.
- Writes take effect at the edge ending the access cycle. A W1C on an enabled bit drops `irq` at that edge unless another enabled bit is set.
- No back-pressure and no handshake: one access per cycle, always accepted.

## Structure
- Package `mmio_pkg` holds:
  - Register offsets SW_STATE_OFF=0, SW_CHANGED_OFF=1, SW_IRQ_EN_OFF=2.
  - Base-region constants shared with `addressDecoder` (2'b10 for switches, 2'b01 for LEDs).
- Sub-module `switch_debouncer`, instantiated NUM_SWITCHES times:
  - Parameter DEBOUNCE_CYCLES.
  - Ports `clk`, `rst_n`, `raw`, `level`, `changed_pulse`.
  - Contains synchroniser and counter; counter width is $clog2(DEBOUNCE_CYCLES).
- Top level holds SW_CHANGED, SW_IRQ_EN, `irq` register and read mux.

## Test plan
- Reset: hold `switches`=16'hFFFF with `rst_n` low for 3 edges, then release → `readData` 0 during reset. SW_STATE=0x0000FFFF and SW_CHANGED=0x0000FFFF after edge 6 post-release (DEBOUNCE_CYCLES=4).
- Glitch rejection: pulse `switches[3]` high for 3 cycles → SW_STATE and SW_CHANGED stay 0, `irq` stays 0. Hold it for 4 cycles → SW_STATE=0x8 after edge 6 and `irq` stays 0 (IRQ_EN=0).
- Interrupt: write SW_IRQ_EN=0x8, raise `switches[3]` → `irq`=1 on the edge SW_STATE bit 3 sets. Write SW_CHANGED=0x8 → `irq`=0 next edge.
- Set/clear collision: time a W1C of bit 3 for the edge where `switches[3]` falling is accepted → SW_CHANGED bit 3 remains 1.
- Decode gating: write/read offset 2 with `selSwitch`=0 → SW_IRQ_EN unchanged, `readData`=0. Offset 3 read with `selSwitch`=1 → 0. A SW_STATE write is ignored.
